// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the stall/flush sequencer: divider
// handshake FSM encoding, RV32M divide funct3 codes and the NOP bubble word.
package hazard_stall_controller_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    // RV32M funct3 codes that select the multi-cycle divider path
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // addi x0, x0, 0 -- what a flushed pipeline register holds
    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0013;

    // True for any of DIV/DIVU/REM/REMU given an OP-opcode, MULDIV funct7 instruction
    function automatic logic is_div_funct3(input logic [2:0] funct3);
        return (funct3 == F3_DIV) || (funct3 == F3_DIVU) ||
               (funct3 == F3_REM) || (funct3 == F3_REMU);
    endfunction

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use comparator: flags when the ID instruction reads a
// register that the load currently in EX has not yet produced. x0 never hazards.
module hazard_loaduse_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_wb_load,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // Only a real load targeting a non-zero register can create the hazard
    always_comb begin
        load_use = ex_wb_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central stall/flush sequencer for the 5-stage RV32IM pipeline. Controls
// PC, IF/ID, ID/EX and EX/MEM, freezes the pipe while the divider works,
// and keeps stall/flush performance counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wb_load,
    input  logic             ex_is_div,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Timeout counter only ever needs to hold MD_TIMEOUT-1
    localparam int               TMO_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    md_state_t        state;
    md_state_t        state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;
    logic             err_set;
    logic             freeze;
    logic             load_use;

    hazard_loaduse_detect u_loaduse (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_wb_load  (ex_wb_load),
        .load_use    (load_use)
    );

    // FSM state and divider timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_next;
        end
    end

    // Next state plus zero-latency pipeline controls; freeze beats branch beats load-use
    always_comb begin
        state_next    = state;
        tmo_next      = tmo_cnt;
        err_set       = 1'b0;
        freeze        = 1'b0;
        md_start      = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        md_busy       = (state == MD_WAIT);

        case (state)
            IDLE: begin
                if (ex_is_div) begin
                    freeze     = 1'b1;
                    md_start   = 1'b1;
                    state_next = MD_WAIT;
                    tmo_next   = '0;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    state_next = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    freeze   = 1'b1;
                    tmo_next = tmo_cnt + TMO_W'(1);
                end
            end
        endcase

        if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end

        if (rst) begin
            state_next    = IDLE;
            tmo_next      = '0;
            err_set       = 1'b0;
            md_start      = 1'b0;
            md_busy       = 1'b0;
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_ex_en      = 1'b1;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_bubble = 1'b0;
        end
    end

    // Sticky divider-timeout flag and wrapping performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_error  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            md_error <= md_error | err_set;
            if (!pc_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Testbench for hazard_stall_controller: table-driven single-cycle hazard
// vectors followed by hand-written divider handshake sequences.
module tb_hazard_stall_controller;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 32;

    // Packed view of the combinational controls:
    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, md_start, md_busy}
    localparam logic [7:0] O_IDLE    = 8'b1101_0000;
    localparam logic [7:0] O_LU      = 8'b0001_1000;
    localparam logic [7:0] O_FLUSH   = 8'b1111_1000;
    localparam logic [7:0] O_START   = 8'b0000_0110;
    localparam logic [7:0] O_WAIT    = 8'b0000_0101;
    localparam logic [7:0] O_RELEASE = 8'b1101_0001;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_wb_load;
    logic             ex_is_div;
    logic             ex_branch_taken;
    logic             md_done;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_bubble;
    logic             md_start;
    logic             md_busy;
    logic             md_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [7:0]       outs;

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int pulses_before;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       load;
        logic       br;
        logic       done;
        logic [7:0] exp_out;
        int         stall_inc;
        int         flush_inc;
    } vec_t;

    vec_t vecs[10];

    hazard_stall_controller #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_wb_load      (ex_wb_load),
        .ex_is_div       (ex_is_div),
        .ex_branch_taken (ex_branch_taken),
        .md_done         (md_done),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_bubble   (ex_mem_bubble),
        .md_start        (md_start),
        .md_busy         (md_busy),
        .md_error        (md_error),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_bubble, md_start, md_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count divider start pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (md_start && !rst) begin
            start_pulses = start_pulses + 1;
        end
    end

    function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2,
                                 input logic [4:0] rd, input logic load,
                                 input logic br, input logic done,
                                 input logic [7:0] exp_out,
                                 input int stall_inc, input int flush_inc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.rd = rd; v.load = load; v.br = br; v.done = done;
        v.exp_out = exp_out; v.stall_inc = stall_inc; v.flush_inc = flush_inc;
        return v;
    endfunction

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2,
                                 input logic [4:0] rd, input logic load,
                                 input logic div, input logic br, input logic done);
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs1     = use1;
        id_uses_rs2     = use2;
        ex_rd           = rd;
        ex_wb_load      = load;
        ex_is_div       = div;
        ex_branch_taken = br;
        md_done         = done;
        #1;
    endtask

    task automatic divStim(input logic div, input logic done);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, div, 1'b0, done);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string name);
        checkOutput({name, " stall_cnt"}, stall_cnt, exp_stall);
        checkOutput({name, " flush_cnt"}, flush_cnt, exp_flush);
    endtask

    initial begin
        vecs[0] = mkv(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, O_IDLE,  0, 0);
        vecs[1] = mkv(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_LU,    1, 0);
        vecs[2] = mkv(5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_IDLE,  0, 0);
        vecs[3] = mkv(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, O_LU,    1, 0);
        vecs[4] = mkv(5'd1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, O_IDLE,  0, 0);
        vecs[5] = mkv(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_IDLE,  0, 0);
        vecs[6] = mkv(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_IDLE,  0, 0);
        vecs[7] = mkv(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, O_FLUSH, 0, 1);
        vecs[8] = mkv(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_FLUSH, 0, 1);
        vecs[9] = mkv(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, O_IDLE,  0, 0);

        // Reset: outputs forced even with a divide and a hazard presented
        rst = 1'b1;
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("reset outputs", outs, O_IDLE);
        checkOutput("reset md_error", md_error, 0);
        checkCounters("reset");
        tick();
        rst = 1'b0;
        divStim(1'b0, 1'b0);
        checkOutput("post-reset idle", outs, O_IDLE);

        // Single-cycle hazard table, FSM idle throughout
        for (int i = 0; i < 10; i++) begin
            tick();
            applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2,
                          vecs[i].rd, vecs[i].load, 1'b0, vecs[i].br, vecs[i].done);
            checkOutput($sformatf("vec%0d outs", i), outs, vecs[i].exp_out);
            tick();
            exp_stall = exp_stall + vecs[i].stall_inc;
            exp_flush = exp_flush + vecs[i].flush_inc;
            checkCounters($sformatf("vec%0d", i));
            divStim(1'b0, 1'b0);
        end

        // Divide with md_done four cycles after start
        pulses_before = start_pulses;
        divStim(1'b1, 1'b0);
        checkOutput("divA start", outs, O_START);
        tick();
        exp_stall = exp_stall + 1;
        for (int k = 1; k <= 3; k++) begin
            divStim(1'b1, 1'b0);
            checkOutput($sformatf("divA wait%0d", k), outs, O_WAIT);
            tick();
            exp_stall = exp_stall + 1;
        end
        divStim(1'b1, 1'b1);
        checkOutput("divA release", outs, O_RELEASE);
        tick();
        divStim(1'b0, 1'b0);
        checkOutput("divA idle", outs, O_IDLE);
        checkCounters("divA");
        checkOutput("divA start pulses", start_pulses - pulses_before, 1);
        checkOutput("divA md_error", md_error, 0);

        // Divider never answers: eight frozen cycles then forced release
        divStim(1'b1, 1'b0);
        checkOutput("tmo start", outs, O_START);
        tick();
        exp_stall = exp_stall + 1;
        for (int k = 1; k <= 7; k++) begin
            divStim(1'b1, 1'b0);
            checkOutput($sformatf("tmo wait%0d", k), outs, O_WAIT);
            tick();
            exp_stall = exp_stall + 1;
        end
        divStim(1'b1, 1'b0);
        checkOutput("tmo release", outs, O_RELEASE);
        checkOutput("tmo md_error before", md_error, 0);
        tick();
        divStim(1'b0, 1'b0);
        checkOutput("tmo idle", outs, O_IDLE);
        checkOutput("tmo md_error set", md_error, 1);
        tick();
        tick();
        checkOutput("tmo md_error sticky", md_error, 1);
        checkCounters("tmo");

        // Reset pulsed on the second MD_WAIT cycle
        divStim(1'b1, 1'b0);
        tick();
        divStim(1'b1, 1'b0);
        tick();
        divStim(1'b1, 1'b0);
        checkOutput("rst pre wait2", outs, O_WAIT);
        rst = 1'b1;
        #1;
        checkOutput("rst mid-wait outs", outs, O_IDLE);
        checkOutput("rst mid-wait md_error", md_error, 0);
        exp_stall = 0;
        exp_flush = 0;
        checkCounters("rst mid-wait");
        tick();
        rst = 1'b0;
        pulses_before = start_pulses;
        divStim(1'b0, 1'b0);
        checkOutput("rst after idle", outs, O_IDLE);
        tick();
        checkOutput("rst no restart", start_pulses - pulses_before, 0);
        checkCounters("rst after");

        // Back-to-back divides: two separate handshakes
        pulses_before = start_pulses;
        divStim(1'b1, 1'b0);
        checkOutput("b2b first start", outs, O_START);
        tick();
        divStim(1'b1, 1'b0);
        checkOutput("b2b first wait", outs, O_WAIT);
        tick();
        divStim(1'b1, 1'b1);
        checkOutput("b2b first release", outs, O_RELEASE);
        tick();
        exp_stall = exp_stall + 2;
        divStim(1'b1, 1'b0);
        checkOutput("b2b second start", outs, O_START);
        tick();
        divStim(1'b1, 1'b0);
        checkOutput("b2b second wait", outs, O_WAIT);
        tick();
        divStim(1'b1, 1'b1);
        checkOutput("b2b second release", outs, O_RELEASE);
        tick();
        exp_stall = exp_stall + 2;
        divStim(1'b0, 1'b0);
        checkOutput("b2b idle", outs, O_IDLE);
        checkOutput("b2b start pulses", start_pulses - pulses_before, 2);
        checkCounters("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the RV32IM 5-stage pipeline. Drives the enable and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use hazards, flushes on taken branches and jumps, and runs a handshake FSM that freezes the pipeline while the multi-cycle divider in EX works.
- Keeps stall and flush performance counters.
- Sits beside the ID/EX register; consumes ID-stage register indices plus EX-stage control fields.

Parameters:
- MD_TIMEOUT, 64: max cycles to wait for md_done before aborting.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination index of instruction in EX
- ex_wb_load  in  1  EX instruction is a load
- ex_is_div  in  1  EX holds DIV/DIVU/REM/REMU (multi-cycle)
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- md_done  in  1  divider result valid (1-cycle pulse)
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX clear to NOP bubble
- ex_mem_bubble  out  1  EX/MEM captures NOP instead of EX result
- md_start  out  1  divider start pulse
- md_busy  out  1  FSM not IDLE
- md_error  out  1  sticky; set on divider timeout
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (async): state=IDLE, timeout counter=0, stall_cnt=0, flush_cnt=0, md_error=0.
- While rst is high, outputs are forced: pc_en=if_id_en=id_ex_en=1; all flushes, ex_mem_bubble and md_start =0; md_busy=0.
- Control outputs are combinational from the registered state plus current inputs. Zero-latency: they act on the same clock edge.
- FSM states: IDLE, MD_WAIT.
- IDLE with ex_is_div=1: assert md_start=1 for this cycle only, plus pc_en=if_id_en=id_ex_en=0 and ex_mem_bubble=1. Next state MD_WAIT; timeout counter cleared.
- MD_WAIT:
  - Default: same freeze (enables 0, ex_mem_bubble=1) and md_start=0; timeout counter increments each cycle.
  - md_done=1: release, with all enables 1 and ex_mem_bubble=0 so the result enters EX/MEM. Next state IDLE.
  - Timeout counter reaches MD_TIMEOUT-1 without md_done: set md_error (sticky until rst) and release as if done. Next state IDLE.
- md_done in IDLE is ignored. md_done in the same cycle as entry to MD_WAIT is not possible; the divider takes at least 2 cycles.
- Re-entry after release: the div instruction advances out of EX on the release edge, so ex_is_div is not seen twice for the same instruction. Back-to-back divs start again from IDLE on the next cycle.
- Taken branch (FSM not freezing): if_id_flush=1, id_ex_flush=1, pc_en=1. flush_cnt increments by 1 at the clock edge.
- Load-use hazard: ex_wb_load && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle.
  - No state needed; the load leaves EX next cycle.
- Priority, highest first: divider freeze > taken branch > load-use. A taken branch with a simultaneous load-use produces a flush only, no stall.
- ex_is_div and ex_branch_taken are never both 1. If they are, the freeze wins and the branch is held until release.
- x0 never causes a hazard.
- stall_cnt increments on every cycle where pc_en=0, excluding reset. stall_cnt and flush_cnt wrap modulo 2^CNT_W.
- Reset asserted mid-MD_WAIT: immediate IDLE with no md_start. The divider must be reset by the same rst.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding (IDLE=1'b0, MD_WAIT=1'b1).
  - RV32M funct3 constants for DIV/DIVU/REM/REMU, used by the decoder to form ex_is_div.
  - The NOP-bubble constant used by the flush paths.
- One natural sub-module: hazard_loaduse_detect (pure combinational comparator). Everything else stays in the top module.

Test Plan:
- Load-use: ex_wb_load=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1. Same stimulus with ex_rd=0 -> no stall.
- Taken branch concurrent with load-use hazard -> if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt +1; stall_cnt unchanged.
- ex_is_div=1, md_done pulses 4 cycles after start:
  - md_start high exactly 1 cycle.
  - pc_en/if_id_en/id_ex_en=0 and ex_mem_bubble=1 for 4 cycles; release in the md_done cycle.
  - stall_cnt +4; md_busy high during MD_WAIT.
- Divider never responds (MD_TIMEOUT=8) -> release after 8 frozen cycles; md_error=1 and stays 1 until rst.
- rst pulsed on the 2nd MD_WAIT cycle -> state IDLE, counters 0, md_error 0, enables 1; md_start does not re-fire unless ex_is_div is still 1 after rst deasserts.
- Two consecutive divs -> two separate md_start pulses, each followed by an independent wait-and-release.
